// File: rtl/mips_pkg.sv
// mips_pkg
// Shared MIPS decode-path definitions.
//   EXT_OP_W   : width of the immediate extension-mode field
//   ext_op_t   : extension modes (SIGN, ZERO, UPPER/LUI, BRANCH offset)
package mips_pkg;

    localparam int unsigned EXT_OP_W = 2;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_op_t;

endpackage

// File: rtl/imm_ext_func.sv
// imm_ext_func
// Purely combinational immediate extender.
//   instr   (in,  IN_W)     : raw immediate field
//   ext_op  (in,  EXT_OP_W) : extension mode (mips_pkg::ext_op_t encoding)
//   ext_imm (out, OUT_W)    : extended operand
// Requires OUT_W >= IN_W + 2 so the branch shift only drops sign copies.
module imm_ext_func
    import mips_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]     instr,
    input  logic [EXT_OP_W-1:0] ext_op,
    output logic [OUT_W-1:0]    ext_imm
);

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] branch_ext;

    always_comb begin
        sign_ext   = {{(OUT_W-IN_W){instr[IN_W-1]}}, instr};
        zero_ext   = {{(OUT_W-IN_W){1'b0}}, instr};
        upper_ext  = {instr, {(OUT_W-IN_W){1'b0}}};
        // Word-offset form: sign extension scaled by 4, top two bits dropped.
        branch_ext = {sign_ext[OUT_W-3:0], 2'b00};
    end

    always_comb begin
        ext_imm = sign_ext;
        case (ext_op)
            EXT_SIGN:   ext_imm = sign_ext;
            EXT_ZERO:   ext_imm = zero_ext;
            EXT_UPPER:  ext_imm = upper_ext;
            EXT_BRANCH: ext_imm = branch_ext;
            default:    ext_imm = sign_ext;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage
// Registered, handshaked immediate-generation stage with a 2-entry skid
// buffer (OUT drives the outputs, SKID absorbs one beat of back-pressure).
//   CLK, RST (sync, active-high), Flush (sync discard of held entries)
//   InValid/InReady, Instr[IN_W], ExtOp[2], InTag[TAG_W] : upstream side
//   OutValid/OutReady, ExtImm[OUT_W], OutTag[TAG_W]       : downstream side
// ExtImm/OutTag come straight from the OUT register; InReady is
// combinational from SKID occupancy and Flush.
module imm_ext_stage
    import mips_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Flush,
    input  logic                InValid,
    output logic                InReady,
    input  logic [IN_W-1:0]     Instr,
    input  logic [EXT_OP_W-1:0] ExtOp,
    input  logic [TAG_W-1:0]    InTag,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [OUT_W-1:0]    ExtImm,
    output logic [TAG_W-1:0]    OutTag
);

    logic [OUT_W-1:0] new_imm;

    logic             out_valid;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;

    logic             skid_valid;
    logic [OUT_W-1:0] skid_imm;
    logic [TAG_W-1:0] skid_tag;

    logic             in_hs;
    logic             out_hs;
    logic             out_free;

    imm_ext_func #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .instr   (Instr),
        .ext_op  (ExtOp),
        .ext_imm (new_imm)
    );

    assign InReady  = !skid_valid && !Flush;
    assign OutValid = out_valid;
    assign ExtImm   = out_imm;
    assign OutTag   = out_tag;

    assign in_hs    = InValid && InReady;
    assign out_hs   = out_valid && OutReady;
    // OUT can take a new entry when it is empty or is being consumed now.
    assign out_free = !out_valid || out_hs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
        end else if (Flush) begin
            // A concurrent output handshake still counts as consumed.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                // InReady was low, so no input can be accepted this cycle.
                out_valid  <= 1'b1;
                out_imm    <= skid_imm;
                out_tag    <= skid_tag;
                skid_valid <= 1'b0;
            end else if (in_hs) begin
                out_valid <= 1'b1;
                out_imm   <= new_imm;
                out_tag   <= InTag;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_hs) begin
            skid_valid <= 1'b1;
            skid_imm   <= new_imm;
            skid_tag   <= InTag;
        end
    end

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage
// Self-checking bench for imm_ext_stage: table vectors, directed
// multi-cycle sequences, and randomized traffic against a queue model.
module tb_imm_ext_stage;
    import mips_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, Flush, InValid, OutReady;
    logic        InReady, OutValid;
    logic [15:0] Instr;
    logic [1:0]  ExtOp;
    logic [4:0]  InTag, OutTag;
    logic [31:0] ExtImm;

    // Narrow instance for the parameter sweep.
    logic        p_valid, p_ready, p_in_ready, p_out_valid;
    logic [11:0] p_instr;
    logic [1:0]  p_op;
    logic [4:0]  p_tag, p_out_tag;
    logic [23:0] p_imm;

    always #5 CLK = ~CLK;

    imm_ext_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .CLK(CLK), .RST(RST), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .Instr(Instr), .ExtOp(ExtOp), .InTag(InTag),
        .OutValid(OutValid), .OutReady(OutReady),
        .ExtImm(ExtImm), .OutTag(OutTag)
    );

    imm_ext_stage #(.IN_W(12), .OUT_W(24), .TAG_W(5)) dut_narrow (
        .CLK(CLK), .RST(RST), .Flush(1'b0),
        .InValid(p_valid), .InReady(p_in_ready),
        .Instr(p_instr), .ExtOp(p_op), .InTag(p_tag),
        .OutValid(p_out_valid), .OutReady(p_ready),
        .ExtImm(p_imm), .OutTag(p_out_tag)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  tag;
    } ent_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] instr;
        logic [31:0] exp;
    } vec_t;

    ent_t q[$];
    vec_t tbl[8];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Reference extension from the arithmetic meaning of each mode.
    function automatic logic [31:0] ref_ext(logic [1:0] op, logic [15:0] v);
        logic [31:0] s;
        s = (v >= 16'h8000) ? (32'(v) + 32'hFFFF_0000) : 32'(v);
        case (op)
            2'd0:    return s;
            2'd1:    return 32'(v);
            2'd2:    return 32'(v) * 32'd65536;
            default: return s * 32'd4;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: check outputs against the 2-deep FIFO model at the falling
    // edge, advance the model with the driven inputs, return 1 after posedge.
    task automatic step();
        @(negedge CLK);
        if (!RST) begin
            chk("in_ready",  32'(InReady),  32'((q.size() < 2) && !Flush));
            chk("out_valid", 32'(OutValid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("ext_imm", ExtImm, q[0].imm);
                chk("out_tag", 32'(OutTag), 32'(q[0].tag));
            end
        end
        if (RST || Flush) begin
            q.delete();
        end else begin
            logic acc;
            acc = InValid && (q.size() < 2);
            if (OutReady && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back('{imm: ref_ext(ExtOp, Instr), tag: InTag});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(logic [15:0] v, logic [1:0] op, logic [4:0] tag);
        InValid = 1'b1;
        Instr   = v;
        ExtOp   = op;
        InTag   = tag;
    endtask

    initial begin
        tbl[0] = '{2'd0, 16'h8004, 32'hFFFF_8004};
        tbl[1] = '{2'd1, 16'h8004, 32'h0000_8004};
        tbl[2] = '{2'd2, 16'h8004, 32'h8004_0000};
        tbl[3] = '{2'd3, 16'h8004, 32'hFFFE_0010};
        tbl[4] = '{2'd0, 16'h7FFF, 32'h0000_7FFF};
        tbl[5] = '{2'd3, 16'h7FFF, 32'h0001_FFFC};
        tbl[6] = '{2'd1, 16'hFFFF, 32'h0000_FFFF};
        tbl[7] = '{2'd3, 16'hFFFF, 32'hFFFF_FFFC};

        RST = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        Instr = '0; ExtOp = '0; InTag = '0;
        p_valid = 1'b0; p_ready = 1'b1; p_instr = '0; p_op = '0; p_tag = '0;
        step();
        step();
        RST = 1'b0;
        chk("rst_out_valid", 32'(OutValid), 32'd0);
        chk("rst_ext_imm",   ExtImm,        32'd0);
        chk("rst_out_tag",   32'(OutTag),   32'd0);
        chk("rst_in_ready",  32'(InReady),  32'd1);

        // Table vectors, one cycle latency each.
        OutReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].instr, tbl[i].op, 5'(i));
            step();
            InValid = 1'b0;
            chk("tbl_valid", 32'(OutValid), 32'd1);
            chk("tbl_imm",   ExtImm,        tbl[i].exp);
        end
        step();

        // Parameter sweep on the 12->24 instance.
        p_valid = 1'b1; p_instr = 12'h800; p_op = 2'd0; p_tag = 5'd3;
        step();
        chk("narrow_valid", 32'(p_out_valid), 32'd1);
        chk("narrow_sign",  32'(p_imm),       32'h00FF_F800);
        p_instr = 12'h801; p_op = 2'd3;
        step();
        chk("narrow_branch", 32'(p_imm), 32'h00FF_E004);
        p_valid = 1'b0;
        step();

        // Streaming: 8 back-to-back, tags 0..7.
        for (int i = 0; i < 8; i++) begin
            drive(16'(i * 3), 2'd1, 5'(i));
            step();
            chk("stream_valid", 32'(OutValid), 32'd1);
            chk("stream_tag",   32'(OutTag),   32'(i));
        end
        InValid = 1'b0;
        step();

        // Stall: tags 1, 2 with OutReady low.
        OutReady = 1'b0;
        drive(16'h0011, 2'd0, 5'd1);
        step();
        drive(16'h0022, 2'd0, 5'd2);
        step();
        InValid = 1'b0;
        chk("stall_in_ready", 32'(InReady), 32'd0);
        chk("stall_tag",      32'(OutTag),  32'd1);
        step();
        chk("stall_hold_tag", 32'(OutTag), 32'd1);
        chk("stall_hold_imm", ExtImm,      32'h0000_0011);
        OutReady = 1'b1;
        step();
        chk("drain_tag2",  32'(OutTag),   32'd2);
        chk("drain_ready", 32'(InReady),  32'd1);
        step();
        chk("drain_empty", 32'(OutValid), 32'd0);

        // Flush with OUT and SKID full plus a concurrent input.
        OutReady = 1'b0;
        drive(16'h0033, 2'd0, 5'd3);
        step();
        drive(16'h0044, 2'd0, 5'd4);
        step();
        chk("full_in_ready", 32'(InReady), 32'd0);
        drive(16'h0055, 2'd0, 5'd5);
        Flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(InReady), 32'd0);
        step();
        Flush = 1'b0; InValid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(OutValid), 32'd0);
        chk("flush_in_ready",  32'(InReady),  32'd1);
        step();

        // Reset mid-stall, then 1-cycle latency afterwards.
        drive(16'h0066, 2'd2, 5'd6);
        step();
        drive(16'h0077, 2'd2, 5'd7);
        step();
        drive(16'h0088, 2'd2, 5'd8);
        RST = 1'b1;
        step();
        RST = 1'b0; InValid = 1'b0;
        chk("mrst_out_valid", 32'(OutValid), 32'd0);
        chk("mrst_ext_imm",   ExtImm,        32'd0);
        chk("mrst_out_tag",   32'(OutTag),   32'd0);
        chk("mrst_in_ready",  32'(InReady),  32'd1);
        OutReady = 1'b1;
        drive(16'h1234, 2'd1, 5'd9);
        step();
        InValid = 1'b0;
        chk("post_rst_valid", 32'(OutValid), 32'd1);
        chk("post_rst_tag",   32'(OutTag),   32'd9);
        chk("post_rst_imm",   ExtImm,        32'h0000_1234);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            InValid  = 1'($urandom_range(0, 1));
            OutReady = ($urandom_range(0, 3) != 0);
            Flush    = ($urandom_range(0, 31) == 0);
            Instr    = 16'($urandom);
            ExtOp    = 2'($urandom_range(0, 3));
            InTag    = 5'($urandom);
            step();
        end
        InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Registered, handshaked immediate-generation stage for the MIPS pipeline decode path. It replaces the purely combinational sign extender. It accepts an `IN_W`-bit immediate together with a 2-bit extension mode and a passthrough tag, and produces an `OUT_W`-bit operand one cycle later. A 2-entry skid buffer sustains full throughput under downstream back-pressure, and a flush input discards in-flight entries on branch/jump redirect.

## Interface
Parameters:
- `IN_W`, default 16: immediate field width.
- `OUT_W`, default 32: output operand width. Must satisfy `OUT_W >= IN_W + 2`.
- `TAG_W`, default 5: sideband tag width (e.g. destination register number). Carried unchanged.

Ports:
- `CLK`, in, 1: single clock. All state updates on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `Flush`, in, 1: discard all held entries. Synchronous.
- `InValid`, in, 1: upstream has a valid immediate.
- `InReady`, out, 1: stage can accept this cycle.
- `Instr`, in, `IN_W`: raw immediate field.
- `ExtOp`, in, 2: extension mode. Encodings: 00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH.
- `InTag`, in, `TAG_W`: sideband tag.
- `OutValid`, out, 1: `ExtImm`/`OutTag` are valid.
- `OutReady`, in, 1: downstream accepts this cycle.
- `ExtImm`, out, `OUT_W`: extended immediate.
- `OutTag`, out, `TAG_W`: tag of the presented entry.

## Operation
Extension function `ext(Instr, ExtOp)`, computed combinationally at the input:
- SIGN: `Instr` with `OUT_W-IN_W` copies of `Instr[IN_W-1]` prepended. Uses the parameter, never a hard 16.
- ZERO: `Instr` with `OUT_W-IN_W` zeros prepended.
- UPPER: `{Instr, (OUT_W-IN_W) zeros}`. This is the LUI form.
- BRANCH: the SIGN result shifted left 2. The top 2 bits are dropped and `[1:0]` are zero.

Storage is two entries, OUT (drives the outputs) and SKID. Each entry holds `{valid, imm, tag}`.
- An input handshake occurs when `InValid && InReady`. An output handshake occurs when `OutValid && OutReady`.
- `InReady = !skid_valid && !Flush`. This is combinational from registered state plus `Flush`.
- `OutValid = out_valid`. `ExtImm`/`OutTag` come directly from the OUT register.

Per-edge update, in priority order:
1. `RST`: clear both valids, `ExtImm`=0, `OutTag`=0.
2. `Flush`: clear both valids. Data registers are don't-care. The input is not accepted, because `InReady` is 0.
3. Otherwise:
   - OUT empty, or output handshake, with SKID valid: SKID moves to OUT and SKID is cleared. An input accepted in the same cycle is impossible, since `InReady` was 0.
   - OUT empty, or output handshake, with SKID empty: an accepted input loads OUT. With no input, OUT becomes invalid.
   - OUT full with no output handshake: an accepted input loads SKID.
- Order is preserved. Data is never lost and never duplicated.

## Timing
- Latency: 1 cycle from input handshake to `OutValid` when OUT is empty.
- Throughput: 1 per cycle while `OutReady` stays high.
- After one stall cycle SKID holds an entry and `InReady` is 0. It returns to 1 on the cycle after the output handshake that drains SKID into OUT.
- Output values are stable while `OutValid && !OutReady`.
- Reset values: `OutValid`=0, `ExtImm`=0, `OutTag`=0. `InReady`=1 from the first cycle after `RST` deasserts. While `RST` is high, `InReady` follows the cleared state, and any input presented is discarded by reset priority.
- Reset or flush mid-stall: both entries are dropped. `OutValid`=0 next cycle and `InReady`=1 next cycle.
- Simultaneous `Flush` and input: flush wins, nothing accepted.
- Simultaneous `Flush` and output handshake: the presented entry counts as consumed by downstream. The stage still clears.

## Structure
- Shared package `mips_pkg`: `ExtOp` encodings (`EXT_SIGN`, `EXT_ZERO`, `EXT_UPPER`, `EXT_BRANCH`) and the 2-bit op width constant.
- Sub-module `imm_ext_func`: purely combinational, parameterised by `IN_W`/`OUT_W`, implementing `ext()`.
- The skid-buffer control lives in `imm_ext_stage`.

## Test plan
- SIGN/ZERO/UPPER/BRANCH with `Instr`=16'h8004, `OutReady`=1. Required `ExtImm` one cycle later: 32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010.
- Streaming 8 back-to-back inputs with tags 0..7 and `OutReady`=1. `OutValid` stays high for 8 consecutive cycles, tags appear in order, and `InReady` never drops.
- Stall: two inputs (tags 1, 2), `OutReady`=0. `InReady`=0 after the second is accepted, tag 1 is held stable, and raising `OutReady` yields tags 1 then 2 on consecutive cycles.
- Flush with OUT and SKID both full. Next cycle `OutValid`=0 and `InReady`=1. A concurrent `InValid` is not accepted.
- `RST` asserted mid-stream: next cycle `OutValid`=0, `ExtImm`=0, `OutTag`=0. The first post-reset input emerges with 1-cycle latency.
- Parameter sweep with `IN_W`=12, `OUT_W`=24, SIGN, 12'h800. Required `ExtImm`=24'hFFF800.
